rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 83 ++++++++
 tb/tb_rom_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational ROM read port between instruction fetch and data load.
// Grants are combinational; each response follows its grant by exactly one cycle, at one word per cycle.
module rom_arbiter #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  input  logic                     ld_req,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  output logic                     ld_gnt,
  output logic                     ld_rvalid,
  output logic                     ld_err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_instr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_LD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     prio_ld_q, prio_ld_d;   // 1 = load wins a tie
  logic [ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;

  // Grants are gated by reset so nothing is accepted while rst_n is low.
  assign if_gnt = rst_n & if_req & (~ld_req | ~prio_ld_q);
  assign ld_gnt = rst_n & ld_req & (~if_req | prio_ld_q);

  always_comb begin
    state_d    = IDLE;
    prio_ld_d  = prio_ld_q;
    rom_addr_d = rom_addr_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    rom_addr   = rom_addr_q;
    if (if_gnt) begin
      state_d    = RESP_IF;
      prio_ld_d  = 1'b1;
      rom_addr   = if_addr;
      rom_addr_d = if_addr;
      rdata_d    = rom_instr;
    end else if (ld_gnt) begin
      state_d    = RESP_LD;
      prio_ld_d  = 1'b0;
      rom_addr   = ld_addr;
      rom_addr_d = ld_addr;
      rdata_d    = rom_instr;
      err_d      = (ld_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_ld_q  <= 1'b0;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_ld_q  <= prio_ld_d;
      rom_addr_q <= rom_addr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign if_rvalid = (state_q == RESP_IF);
  assign ld_rvalid = (state_q == RESP_LD);
  assign ld_err    = (state_q == RESP_LD) & err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and random stimulus with a scoreboard of expected responses for rom_arbiter.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, ld_req = 1'b0;
  logic [11:0] if_addr = '0, ld_addr = '0;
  logic        if_gnt, if_rvalid, ld_gnt, ld_rvalid, ld_err;
  logic [31:0] rdata, rom_instr;
  logic [11:0] rom_addr;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .ld_err(ld_err), .rdata(rdata), .rom_addr(rom_addr), .rom_instr(rom_instr)
  );

  function automatic logic [31:0] rom_fn(input logic [11:0] a);
    if (a == 12'h004) return 32'h00500093;
    return {a, 8'h5A, ~a};
  endfunction

  assign rom_instr = rom_fn(rom_addr);

  typedef struct packed {
    logic        is_ld;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_ptr = 1'b0;
  logic [11:0] exp_hold = '0;
  logic [31:0] exp_rdata = '0;
  logic        last_ig, last_lg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ir, input logic [11:0] ia,
                      input logic lr, input logic [11:0] la);
    logic  eig, elg;
    resp_t e;
    rst_n = rst; if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la;
    #2;
    eig = rst & ir & (~lr | ~exp_ptr);
    elg = rst & lr & (~ir | exp_ptr);
    last_ig = if_gnt;
    last_lg = ld_gnt;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
    chk("ld_gnt", {31'd0, ld_gnt}, {31'd0, elg});
    if (rst) chk("rom_addr", {20'd0, rom_addr}, {20'd0, eig ? ia : (elg ? la : exp_hold)});
    if (eig) sb.push_back('{1'b0, rom_fn(ia), 1'b0});
    if (elg) sb.push_back('{1'b1, rom_fn(la), la[1:0] != 2'b00});
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_ptr = 1'b0; exp_hold = '0; exp_rdata = '0; sb.delete();
    end else if (eig) begin
      exp_ptr = 1'b1; exp_hold = ia;
    end else if (elg) begin
      exp_ptr = 1'b0; exp_hold = la;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_rdata = e.data;
      chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, ~e.is_ld});
      chk("ld_rvalid", {31'd0, ld_rvalid}, {31'd0, e.is_ld});
      chk("rdata", rdata, e.data);
      chk("ld_err", {31'd0, ld_err}, {31'd0, e.err});
    end else begin
      chk("idle_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("idle_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
      chk("idle_ld_err", {31'd0, ld_err}, 32'd0);
      chk("idle_rdata", rdata, exp_rdata);
    end
  endtask

  initial begin
    // reset
    step(0, 0, 12'h000, 0, 12'h000);
    step(0, 1, 12'h010, 1, 12'h020);
    chk("reset_rdata", rdata, 32'd0);
    // contention straight out of reset: IF, LD, IF, LD
    step(1, 1, 12'h010, 1, 12'h100);
    chk("cont0_if", {31'd0, last_ig}, 32'd1);
    step(1, 1, 12'h014, 1, 12'h104);
    chk("cont1_ld", {31'd0, last_lg}, 32'd1);
    step(1, 1, 12'h014, 1, 12'h108);
    chk("cont2_if", {31'd0, last_ig}, 32'd1);
    step(1, 1, 12'h018, 1, 12'h108);
    chk("cont3_ld", {31'd0, last_lg}, 32'd1);
    // lone fetch
    step(1, 1, 12'h004, 0, 12'h000);
    chk("lone_fetch_rdata", rdata, 32'h00500093);
    chk("lone_fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
    // misaligned and aligned loads
    step(1, 0, 12'h000, 1, 12'h102);
    chk("misaligned_err", {31'd0, ld_err}, 32'd1);
    step(1, 0, 12'h000, 1, 12'h100);
    chk("aligned_err", {31'd0, ld_err}, 32'd0);
    step(1, 0, 12'h000, 1, 12'h103);
    // back-to-back fetches
    step(1, 1, 12'h000, 0, 12'h000);
    step(1, 1, 12'h004, 0, 12'h000);
    step(1, 1, 12'h008, 0, 12'h000);
    chk("b2b_rdata", rdata, rom_fn(12'h008));
    // idle hold
    step(1, 0, 12'hFFF, 0, 12'hEEE);
    step(1, 0, 12'h123, 0, 12'h456);
    step(1, 0, 12'h000, 0, 12'h000);
    chk("idle_rom_addr", {20'd0, rom_addr}, 32'h008);
    // wrap-around address forwarded unchanged
    step(1, 1, 12'hFFE, 0, 12'h000);
    step(1, 0, 12'h000, 1, 12'hFFD);
    // reset mid-operation: grant then reset, then IF must win a tie
    step(1, 1, 12'h040, 0, 12'h000);
    step(1, 0, 12'h000, 1, 12'h044);
    step(0, 1, 12'h048, 1, 12'h04C);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_rvalid", {31'd0, if_rvalid | ld_rvalid}, 32'd0);
    step(1, 1, 12'h050, 1, 12'h054);
    chk("post_rst_if_first", {31'd0, last_ig}, 32'd1);
    // random traffic with occasional reset
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), $urandom_range(0, 1), 12'($urandom),
           $urandom_range(0, 1), 12'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
